writeback_buffer: RTL
=====================

// Module: writeback_buffer
// PURPOSE
//  Write-side front end of the 32x32 register file (x0 hardwired zero). Accepts results from
//  execute/memory via valid/ready and queues them in a small FIFO. Drains one entry per cycle
//  into the register file write port (RW/DA/writeData). Forwards pending (not yet written)
//  values to the two read ports SA/SB, so readers never see stale register data.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >= 2
//  AW     5   register address width
//  DW     32  data width
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high; clears queue state
//  in_valid   in   1        producer presents result
//  in_ready   out  1        buffer can accept this cycle
//  in_addr    in   AW       destination register
//  in_data    in   DW       result value
//  drain_en   in   1        permits a register-file write this cycle
//  RW         out  1        register-file write enable
//  DA         out  AW       register-file write address
//  writeData  out  DW       register-file write data
//  SA         in   AW       read port 1 address, same as the register file sees
//  SB         in   AW       read port 2 address
//  fwd_hit1   out  1        pending entry matches SA
//  fwd_data1  out  DW       forwarded value for SA
//  fwd_hit2   out  1        pending entry matches SB
//  fwd_data2  out  DW       forwarded value for SB
//  count      out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async, immediate): wr_ptr=rd_ptr=0, count=0 -> RW=0, DA=0, writeData=0, in_ready=1,
//    fwd_hit*=0, fwd_data*=0. Storage array not cleared; all reads are gated by valid.
//    Reset mid-operation discards every pending entry; no partial write is issued.
//  - Push: at posedge when in_valid && in_ready && in_addr!=0, store {addr,data} at wr_ptr,
//    wr_ptr+1. A push with in_addr==0 is accepted (handshake completes) but dropped.
//  - in_ready = (count != DEPTH), combinational from registered count only; no same-cycle
//    pop-makes-room path. When full, the producer holds its data.
//  - Pop: RW = drain_en && count!=0 (combinational). DA/writeData = head entry when RW=1,
//    else 0. At posedge with RW=1: rd_ptr+1; the register file captures the same edge.
//  - Latency: entry pushed at edge N on empty queue with drain_en=1 -> RW=1 during cycle N+1,
//    written at edge N+1. Drain throughput: 1 entry/cycle.
//  - Simultaneous push+pop: count unchanged, both pointers advance. Pointers are log2(DEPTH)
//    bits and wrap naturally; full/empty derived from count.
//  - Forwarding (combinational): fwd_hitK = (SK!=0) && some valid entry has addr==SK.
//    fwd_dataK = data of the YOUNGEST matching entry (nearest wr_ptr), else 0.
//    The head entry being written this cycle still forwards (the file updates at the edge).
//    The value on in_* this cycle does NOT forward.
//  - drain_en=0 freezes the queue contents for popping; pushes continue until full.
// TESTING
//  1 Reset: 3 entries queued, drain_en=0, assert reset mid-cycle -> count=0, RW=0,
//    in_ready=1 before next edge; after release, no stale writes.
//  2 Single: empty, drain_en=1, push (5,0xDEADBEEF) at edge N -> cycle N+1: RW=1, DA=5,
//    writeData=0xDEADBEEF; count=0 after edge N+1.
//  3 Full: drain_en=0, push r1..r4 = 0x1..0x4 -> count=4, in_ready=0, 5th held; drain_en=1
//    -> DA 1,2,3,4 on 4 consecutive cycles, then the held 5th entry.
//  4 Forwarding: drain_en=0, push (7,0x11), (7,0x22); SA=7, SB=0 -> fwd_hit1=1,
//    fwd_data1=0x22, fwd_hit2=0; drain one -> still 0x22.
//  5 x0: push (0,0xFFFF) -> handshake completes, count stays 0, RW never 1.
//  6 Stream/wrap: drain_en=1, push 10 back-to-back (r1..r10) -> count<=1 throughout,
//    writes in order r1..r10, pointers wrapped twice.

Source files
------------

// File: rtl/writeback_buffer.sv
// Write-side queue in front of the 32x32 register file: accepts results, drains one per cycle
// into the file's write port, and forwards pending values to the two read ports.
module writeback_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic                       RW,
  output logic [AW-1:0]              DA,
  output logic [DW-1:0]              writeData,
  input  logic [AW-1:0]              SA,
  input  logic [AW-1:0]              SB,
  output logic                       fwd_hit1,
  output logic [DW-1:0]              fwd_data1,
  output logic                       fwd_hit2,
  output logic [DW-1:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic          push;
  logic [PW-1:0] idx;

  // Handshake, drain port and queue bookkeeping
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    RW        = drain_en && (count_q != '0);
    DA        = '0;
    writeData = '0;
    if (RW) begin
      DA        = addr_q[rd_ptr_q];
      writeData = data_q[rd_ptr_q];
    end
    // x0 writes complete the handshake but are never queued
    push     = in_valid && in_ready && (in_addr != '0);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(RW);
    count_d  = count_q + CW'(push) - CW'(RW);
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      addr_d[wr_ptr_q] = in_addr;
      data_d[wr_ptr_q] = in_data;
    end
    count = count_q;
  end

  // Forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = rd_ptr_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((SA != '0) && (addr_q[idx] == SA)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if ((SB != '0) && (addr_q[idx] == SB)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity comes from count and rd_ptr
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
